// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - 8-digit seven-segment scan controller with digit register file
module seg7_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [7:0] digit_mask,
  output logic [3:0] num,
  output logic [2:0] s,
  output logic       blank,
  output logic       tick
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;
  logic [3:0]    digits [8];
  logic [2:0]    next_s;
  logic [2:0]    idx;
  logic          found;
  logic          wrap;

  assign wrap = (cnt == LAST);

  // Rotating priority search starting just after the current digit; holds when no other digit is enabled.
  always_comb begin
    next_s = s;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k < 8; k++) begin
      idx = s + 3'(k);
      if (!found && digit_mask[idx]) begin
        next_s = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      s    <= '0;
      tick <= 1'b0;
      for (int i = 0; i < 8; i++) digits[i] <= '0;
    end else begin
      tick <= wrap;
      if (wrap) begin
        cnt <= '0;
        s   <= next_s;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (wr_en) digits[wr_addr] <= wr_data;
    end
  end

  assign num   = digits[s];
  assign blank = ~digit_mask[s];

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - bench for seg7_scan_ctrl (REFRESH_DIV=4 main, REFRESH_DIV=1 tick check)
module tb_seg7_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [7:0] digit_mask;
  logic [3:0] num, num1;
  logic [2:0] s, s1;
  logic       blank, blank1, tick, tick1;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .digit_mask(digit_mask), .num(num), .s(s), .blank(blank), .tick(tick)
  );

  seg7_scan_ctrl #(.REFRESH_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .digit_mask(digit_mask), .num(num1), .s(s1), .blank(blank1), .tick(tick1)
  );

  typedef struct {
    string      name;
    logic [2:0] s;
    logic [3:0] num;
    logic       blank;
    logic       tick;
  } exp_t;

  typedef struct {
    logic [7:0] mask;
    logic [2:0] s;
    logic       blank;
  } rec_t;

  exp_t       sb[$];
  rec_t       recs[27];
  logic [3:0] mem [8];
  logic [2:0] prev_s;
  int         checks = 0;
  int         errors = 0;

  task automatic expect_out(input string name, input logic [2:0] es, input logic [3:0] en,
                            input logic eb, input logic et);
    exp_t e;
    e.name = name; e.s = es; e.num = en; e.blank = eb; e.tick = et;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({s, num, blank, tick} !== {e.s, e.num, e.blank, e.tick}) begin
        errors++;
        $display("FAIL %s: got s=%0d num=%h blank=%b tick=%b, want s=%0d num=%h blank=%b tick=%b",
                 e.name, s, num, blank, tick, e.s, e.num, e.blank, e.tick);
      end
    end
  endtask

  task automatic check(input string name, input logic [2:0] es, input logic [3:0] en,
                       input logic eb, input logic et);
    expect_out(name, es, en, eb, et);
    drain();
  endtask

  task automatic check_tick1(input string name, input logic et);
    checks++;
    if (tick1 !== et) begin
      errors++;
      $display("FAIL %s: got tick=%b, want %b", name, tick1, et);
    end
  endtask

  task automatic wait_tick(input string name);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tick === 1'b1) break;
    end
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL %s: got tick=%b within 20 cycles, want 1", name, tick);
    end
  endtask

  // Called on the negedge where tick is high; changes the mask mid-slot and runs one full slot.
  task automatic apply_rec(input int i);
    rec_t r;
    r = recs[i];
    digit_mask = r.mask;
    #1 check($sformatf("rec%0d_mask_change", i), prev_s, mem[prev_s], ~r.mask[prev_s], 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rec%0d_mid%0d", i, c), prev_s, mem[prev_s], ~r.mask[prev_s], 1'b0);
    end
    @(negedge clk);
    check($sformatf("rec%0d_tick", i), r.s, mem[r.s], r.blank, 1'b1);
    check_tick1($sformatf("rec%0d_div1_tick", i), 1'b1);
    prev_s = r.s;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) recs[i] = '{8'hFF, 3'(i + 1), 1'b0};
    recs[8]  = '{8'h85, 3'd2, 1'b0};
    recs[9]  = '{8'h85, 3'd7, 1'b0};
    recs[10] = '{8'h85, 3'd0, 1'b0};
    recs[11] = '{8'h85, 3'd2, 1'b0};
    for (int i = 12; i < 22; i++) recs[i] = '{8'h00, 3'd2, 1'b1};
    recs[22] = '{8'h10, 3'd4, 1'b0};
    recs[23] = '{8'h08, 3'd3, 1'b0};
    recs[24] = '{8'h08, 3'd3, 1'b0};
    recs[25] = '{8'h01, 3'd0, 1'b0};
    recs[26] = '{8'h20, 3'd5, 1'b0};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; digit_mask = 8'hFE;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    check("reset_state", 3'd0, 4'h0, 1'b1, 1'b0);
    check_tick1("reset_div1_tick", 1'b0);
    digit_mask = 8'hFF;
    #1 check("reset_blank_follows_mask", 3'd0, 4'h0, 1'b0, 1'b0);

    @(negedge clk);
    digit_mask = 8'h00;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'(i);
      @(negedge clk);
      mem[i] = 4'(i);
    end
    wr_en = 1'b0;
    wait_tick("align_tick");
    check("align", 3'd0, 4'h0, 1'b1, 1'b1);
    prev_s = 3'd0;

    for (int i = 0; i < 24; i++) apply_rec(i);

    // Mid-slot write to the selected digit, then a write landing on the advance edge.
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'hA;
    #1 check("wr_before_edge", 3'd3, 4'h3, 1'b0, 1'b1);
    mem[3] = 4'hA;
    @(negedge clk);
    wr_en = 1'b0;
    check("wr_visible_next_cycle", 3'd3, 4'hA, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 4'h5; digit_mask = 8'h18;
    @(negedge clk);
    wr_en = 1'b0;
    mem[4] = 4'h5;
    check("wr_on_advance", 3'd4, 4'h5, 1'b0, 1'b1);
    prev_s = 3'd4;

    for (int i = 24; i < 27; i++) apply_rec(i);

    // Asynchronous reset in the middle of the slot showing digit 5.
    rst_n = 1'b0;
    #1 check("async_reset", 3'd0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) mem[i] = '0;
    @(negedge clk);
    digit_mask = 8'hFF;
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("post_reset_cycle%0d", c), 3'd0, 4'h0, 1'b0, 1'b0);
    end
    @(negedge clk);
    check("post_reset_first_tick", 3'd1, 4'h0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
